// File: rtl/register_bank_sb.sv
// Register bank with scoreboard pending bits: two combinational read ports with
// write-through bypass, one write port, and a reservation port for in-flight producers.
module register_bank_sb #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 3,
  parameter bit          ZERO_R0 = 1'b0,
  parameter logic [63:0] RST_R1  = 64'h82,
  parameter logic [63:0] RST_R2  = 64'h83
) (
  input  logic              i_CLK,
  input  logic              i_RST_n,
  input  logic [ADDR_W-1:0] i_AddrReg1,
  input  logic [ADDR_W-1:0] i_AddrReg2,
  output logic [DATA_W-1:0] o_Data1,
  output logic [DATA_W-1:0] o_Data2,
  output logic              o_Busy1,
  output logic              o_Busy2,
  input  logic              i_WriteBack,
  input  logic [ADDR_W-1:0] i_AddrRegDest,
  input  logic [DATA_W-1:0] i_WriteData,
  input  logic              i_Reserve,
  input  logic [ADDR_W-1:0] i_AddrReserve,
  output logic [ADDR_W:0]   o_PendingCount,
  output logic              o_ResvReject
);

  localparam int N = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] R1_INIT = DATA_W'(RST_R1);
  localparam logic [DATA_W-1:0] R2_INIT = DATA_W'(RST_R2);

  // Protocol: i_Reserve and i_WriteBack are single-cycle strobes with no handshake;
  // a refused reservation is reported one cycle later on o_ResvReject.
  logic [DATA_W-1:0] regs [N];
  logic [N-1:0]      pend;
  logic [N-1:0]      pendNext;
  logic [ADDR_W:0]   countNext;
  logic              writeEn;
  logic              resvEn;
  logic              resvRefuse;

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return ZERO_R0 && (addr == '0);
  endfunction

  assign writeEn = i_WriteBack && !isZeroReg(i_AddrRegDest);
  assign resvEn  = i_Reserve && !isZeroReg(i_AddrReserve);
  // A reservation colliding with a same-cycle write-back of that register is accepted.
  assign resvRefuse = resvEn && pend[i_AddrReserve]
                      && !(writeEn && (i_AddrRegDest == i_AddrReserve));

  always_comb begin
    o_Data1 = regs[i_AddrReg1];
    o_Busy1 = pend[i_AddrReg1];
    if (isZeroReg(i_AddrReg1)) begin
      o_Data1 = '0;
      o_Busy1 = 1'b0;
    end else if (writeEn && (i_AddrRegDest == i_AddrReg1)) begin
      o_Data1 = i_WriteData;
      o_Busy1 = 1'b0;
    end
  end

  always_comb begin
    o_Data2 = regs[i_AddrReg2];
    o_Busy2 = pend[i_AddrReg2];
    if (isZeroReg(i_AddrReg2)) begin
      o_Data2 = '0;
      o_Busy2 = 1'b0;
    end else if (writeEn && (i_AddrRegDest == i_AddrReg2)) begin
      o_Data2 = i_WriteData;
      o_Busy2 = 1'b0;
    end
  end

  // Reserve is applied after the write-back clear so it wins on a collision.
  always_comb begin
    pendNext = pend;
    if (writeEn) pendNext[i_AddrRegDest] = 1'b0;
    if (resvEn)  pendNext[i_AddrReserve] = 1'b1;
    countNext = '0;
    for (int i = 0; i < N; i++) begin
      countNext = countNext + {{ADDR_W{1'b0}}, pendNext[i]};
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= (i == 1) ? R1_INIT : (i == 2) ? R2_INIT : '0;
      end
    end else if (writeEn) begin
      regs[i_AddrRegDest] <= i_WriteData;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      pend           <= '0;
      o_PendingCount <= '0;
      o_ResvReject   <= 1'b0;
    end else begin
      pend           <= pendNext;
      o_PendingCount <= countNext;
      o_ResvReject   <= resvRefuse;
    end
  end

endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: directed steps push expected outputs into a queue,
// a negedge monitor pops and compares against the selected instance.
module tb_register_bank_sb;

  logic       clk = 1'b0;
  logic       rstA_n = 1'b0;
  logic       rstB_n = 1'b0;
  logic       nxtRstA = 1'b0;
  logic       nxtRstB = 1'b0;
  logic [2:0] addr1 = '0, addr2 = '0, dest = '0, resvAddr = '0;
  logic       wb = 1'b0, resv = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] aData1, aData2, bData1, bData2;
  logic       aBusy1, aBusy2, bBusy1, bBusy2, aRej, bRej;
  logic [3:0] aCnt, bCnt;

  // Packed expectation: {dut, data1, data2, busy1, busy2, count, reject}
  logic [23:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  register_bank_sb dutA (
    .i_CLK(clk), .i_RST_n(rstA_n),
    .i_AddrReg1(addr1), .i_AddrReg2(addr2),
    .o_Data1(aData1), .o_Data2(aData2), .o_Busy1(aBusy1), .o_Busy2(aBusy2),
    .i_WriteBack(wb), .i_AddrRegDest(dest), .i_WriteData(wdata),
    .i_Reserve(resv), .i_AddrReserve(resvAddr),
    .o_PendingCount(aCnt), .o_ResvReject(aRej)
  );

  register_bank_sb #(.ZERO_R0(1'b1)) dutB (
    .i_CLK(clk), .i_RST_n(rstB_n),
    .i_AddrReg1(addr1), .i_AddrReg2(addr2),
    .o_Data1(bData1), .o_Data2(bData2), .o_Busy1(bBusy1), .o_Busy2(bBusy2),
    .i_WriteBack(wb), .i_AddrRegDest(dest), .i_WriteData(wdata),
    .i_Reserve(resv), .i_AddrReserve(resvAddr),
    .o_PendingCount(bCnt), .o_ResvReject(bRej)
  );

  task automatic step(input string nm, input logic dut,
                      input logic [2:0] a1, input logic [2:0] a2,
                      input logic w, input logic [2:0] d, input logic [7:0] wd,
                      input logic r, input logic [2:0] ra,
                      input logic [7:0] ed1, input logic [7:0] ed2,
                      input logic eb1, input logic eb2,
                      input logic [3:0] ecnt, input logic erej);
    @(posedge clk);
    #1;
    rstA_n   = nxtRstA;
    rstB_n   = nxtRstB;
    addr1    = a1;
    addr2    = a2;
    wb       = w;
    dest     = d;
    wdata    = wd;
    resv     = r;
    resvAddr = ra;
    exp_q.push_back({dut, ed1, ed2, eb1, eb2, ecnt, erej});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [23:0] e;
      logic [23:0] act;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = e[23] ? {1'b1, bData1, bData2, bBusy1, bBusy2, bCnt, bRej}
                  : {1'b0, aData1, aData2, aBusy1, aBusy2, aCnt, aRej};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s got={d1=%h d2=%h b1=%b b2=%b cnt=%0d rej=%b} exp={d1=%h d2=%h b1=%b b2=%b cnt=%0d rej=%b}",
                 nm, act[22:15], act[14:7], act[6], act[5], act[4:1], act[0],
                 e[22:15], e[14:7], e[6], e[5], e[4:1], e[0]);
      end
    end
  end

  logic [2:0] fillAddr [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  logic [7:0] fillData [6] = '{8'h00, 8'h82, 8'h83, 8'h5A, 8'h11, 8'h3C};

  initial begin
    // Plain bank: reset contents
    step("in_reset",    0, 1, 2, 0, 0, 8'h00, 0, 0, 8'h82, 8'h83, 0, 0, 0, 0);
    nxtRstA = 1'b1;
    step("reset_r0r1",  0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h82, 0, 0, 0, 0);
    step("reset_r2r3",  0, 2, 3, 0, 0, 8'h00, 0, 0, 8'h83, 8'h00, 0, 0, 0, 0);
    step("reset_r4r5",  0, 4, 5, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    step("reset_r6r7",  0, 6, 7, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    // Write with bypass, then stored
    step("wr_bypass",   0, 3, 2, 1, 3, 8'h5A, 0, 0, 8'h5A, 8'h83, 0, 0, 0, 0);
    step("wr_stored",   0, 3, 4, 0, 0, 8'h00, 0, 0, 8'h5A, 8'h00, 0, 0, 0, 0);
    // Reserve, busy, write-back clears via bypass
    step("resv_r4",     0, 4, 3, 0, 0, 8'h00, 1, 4, 8'h00, 8'h5A, 0, 0, 0, 0);
    step("busy_r4",     0, 4, 4, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0);
    step("wb_r4",       0, 4, 0, 1, 4, 8'h11, 0, 0, 8'h11, 8'h00, 0, 0, 1, 0);
    step("after_wb_r4", 0, 4, 5, 0, 0, 8'h00, 0, 0, 8'h11, 8'h00, 0, 0, 0, 0);
    // Double reservation
    step("resv_r5",     0, 5, 4, 0, 0, 8'h00, 1, 5, 8'h00, 8'h11, 0, 0, 0, 0);
    step("resv_r5_dup", 0, 5, 5, 0, 0, 8'h00, 1, 5, 8'h00, 8'h00, 1, 1, 1, 0);
    step("reject",      0, 5, 6, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1);
    // Same-cycle reserve and write-back on a pending register
    step("resv_r6",     0, 6, 5, 0, 0, 8'h00, 1, 6, 8'h00, 8'h00, 0, 1, 1, 0);
    step("resv_wb_r6",  0, 6, 7, 1, 6, 8'hC3, 1, 6, 8'hC3, 8'h00, 0, 0, 2, 0);
    step("after_r6",    0, 6, 5, 0, 0, 8'h00, 0, 0, 8'hC3, 8'h00, 1, 1, 2, 0);
    // Write-back to non-pending register
    step("wr_r7",       0, 7, 1, 1, 7, 8'h3C, 0, 0, 8'h3C, 8'h82, 0, 0, 2, 0);
    step("after_r7",    0, 7, 6, 0, 0, 8'h00, 0, 0, 8'h3C, 8'hC3, 0, 1, 2, 0);
    // Fill every pending bit: count must reach N without wrapping
    for (int k = 0; k < 6; k++) begin
      step("fill", 0, fillAddr[k], 5, 0, 0, 8'h00, 1, fillAddr[k],
           fillData[k], 8'h00, 0, 1, 4'(2 + k), 0);
    end
    step("full",        0, 0, 7, 0, 0, 8'h00, 0, 0, 8'h00, 8'h3C, 1, 1, 8, 0);
    // Mid-operation reset: pending and writes discarded
    nxtRstA = 1'b0;
    step("rst_async",   0, 2, 4, 1, 3, 8'hFF, 0, 0, 8'h83, 8'h00, 0, 0, 0, 0);
    step("rst_hold",    0, 2, 4, 1, 3, 8'hFF, 0, 0, 8'h83, 8'h00, 0, 0, 0, 0);
    nxtRstA = 1'b1;
    step("rst_release", 0, 3, 7, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    step("rst_no_wr",   0, 3, 4, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

    // Hard-wired R0 instance
    nxtRstB = 1'b1;
    step("z_reset",     1, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h82, 0, 0, 0, 0);
    step("z_wr_resv0",  1, 0, 0, 1, 0, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    step("z_resv0_2",   1, 0, 2, 0, 0, 8'h00, 1, 0, 8'h00, 8'h83, 0, 0, 0, 0);
    step("z_resv1",     1, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 8'h82, 0, 0, 0, 0);
    step("z_resv2",     1, 1, 0, 0, 0, 8'h00, 1, 2, 8'h82, 8'h00, 1, 0, 1, 0);
    step("z_pending",   1, 2, 1, 0, 0, 8'h00, 0, 0, 8'h83, 8'h82, 1, 1, 2, 0);
    nxtRstB = 1'b0;
    step("z_rst_async", 1, 2, 1, 0, 0, 8'h00, 0, 0, 8'h83, 8'h82, 0, 0, 0, 0);
    nxtRstB = 1'b1;
    step("z_rst_done",  1, 1, 2, 0, 0, 8'h00, 0, 0, 8'h82, 8'h83, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d pending expectations exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_sb.md
REGISTER_BANK_SB -- requirements
Module: register_bank_sb

Interface
REQ-001 Parameter DATA_W, default 8: register width in bits.
REQ-002 Parameter ADDR_W, default 3: address width; depth N = 2^ADDR_W registers.
REQ-003 Parameter ZERO_R0, default 0: 1 = R0 hard-wired to zero and never writable or reservable.
REQ-004 Parameter RST_R1, default 8'h82: reset value of R1, zero-extended or truncated to DATA_W.
REQ-005 Parameter RST_R2, default 8'h83: reset value of R2; all other registers reset to 0.
REQ-006 Port list, one per line:
- i_CLK  in  1  clock; all state updates on posedge.
- i_RST_n  in  1  reset; asynchronous assert, active-low.
- i_AddrReg1  in  ADDR_W  read port 1 address.
- i_AddrReg2  in  ADDR_W  read port 2 address.
- o_Data1  out  DATA_W  read port 1 data.
- o_Data2  out  DATA_W  read port 2 data.
- o_Busy1  out  1  register at i_AddrReg1 has a pending write.
- o_Busy2  out  1  register at i_AddrReg2 has a pending write.
- i_WriteBack  in  1  write enable.
- i_AddrRegDest  in  ADDR_W  write address.
- i_WriteData  in  DATA_W  write data.
- i_Reserve  in  1  mark register i_AddrReserve pending (issue of an in-flight producer).
- i_AddrReserve  in  ADDR_W  register to reserve.
- o_PendingCount  out  ADDR_W+1  number of registers currently pending.
- o_ResvReject  out  1  registered; i_Reserve in previous cycle was refused.

Function
REQ-007 Storage is N x DATA_W registers plus an N-bit pending vector P.
REQ-008 Reads are combinational from addresses; zero read latency.
REQ-009 Write-through bypass: if i_WriteBack=1 and i_AddrRegDest equals a read address, that port outputs i_WriteData in the same cycle.
REQ-010 When i_WriteBack=1, R[i_AddrRegDest] takes i_WriteData at posedge and P[i_AddrRegDest] clears.
REQ-011 o_BusyK = P[i_AddrRegK], except 0 when the bypass of REQ-009 is active for that port.
REQ-012 When i_Reserve=1 and P[i_AddrReserve]=0, P[i_AddrReserve] sets at posedge and o_ResvReject is 0 next cycle.
REQ-013 When i_Reserve=1 and P[i_AddrReserve]=1 (double reservation), P is unchanged and o_ResvReject is 1 next cycle; otherwise o_ResvReject is 0.
REQ-014 Same-cycle reserve and write-back to one register: write completes, P bit ends 1 (reserve wins), no reject.
REQ-015 Write-back to a non-pending register is legal: data written, P unchanged.
REQ-016 ZERO_R0=1: reads of R0 return 0, writes to R0 ignored, no bypass from R0, reserve of R0 ignored without reject, o_Busy for R0 always 0.
REQ-017 o_PendingCount is registered, equals popcount(P) after each edge, range 0..N, never wraps.
REQ-018 Read and write addresses are all ADDR_W wide; no out-of-range address exists.

Reset
REQ-019 While i_RST_n=0, immediately and independently of i_CLK: R1=RST_R1, R2=RST_R2, other registers 0, P=0, o_PendingCount=0, o_ResvReject=0.
REQ-020 Reset asserted mid-operation discards all pending reservations and in-progress writes; no write occurs on a posedge while i_RST_n=0.
REQ-021 First state update after deassertion occurs on the first posedge with i_RST_n=1.

Verification
REQ-022 Reset, read all addresses -> R1=8'h82, R2=8'h83, others 0, o_Busy1=o_Busy2=0, o_PendingCount=0.
REQ-023 Write R3=8'h5A with i_AddrReg1=3 in same cycle -> o_Data1=8'h5A before edge (bypass) and after edge (stored).
REQ-024 Reserve R4, next cycle read R4 -> o_Busy1=1, o_PendingCount=1; write-back R4=8'h11 -> o_Busy1=0 in that cycle via bypass, count 0 after edge.
REQ-025 Reserve R5 twice on consecutive cycles -> second cycle's reject: o_ResvReject=1 for one cycle, count stays 1.
REQ-026 Reserve and write-back R6 same cycle while R6 pending -> R6 holds new data, P[6]=1, count unchanged, no reject.
REQ-027 ZERO_R0=1: write R0=8'hFF, reserve R0 -> reads of R0 return 0, o_Busy 0, count 0, no reject; assert i_RST_n=0 mid-sequence with pending bits set -> count 0 without a clock edge.
